// File: rtl/gfx256_pkg.sv
// gfx256_pkg: shared types and constants for the gfx256 memory arbiters.
//   arb_state_e     : arbiter FSM states (IDLE, READ, DONE)
//   REQ_*           : requester indices on the read arbiter
//   WB_AW / WB_SW   : Wishbone address and byte-select widths
//   WDOG_W          : width of the bus-watchdog counter
//   rr_next()       : round-robin successor of an index, wrapping at n
package gfx256_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    READ = 2'd1,
    DONE = 2'd2
  } arb_state_e;

  localparam int REQ_BLEND = 0;
  localparam int REQ_TEX   = 1;
  localparam int REQ_DEPTH = 2;

  localparam int WB_AW  = 32;
  localparam int WB_SW  = 32;
  localparam int WDOG_W = 16;

  function automatic int rr_next(input int idx, input int n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/gfx256_wbm_read_arbiter_if.sv
// gfx256_wbm_read_arbiter_if: single-beat Wishbone read bus between the
// arbiter (master modport) and video memory (slave modport).
//   wb_cyc_o/wb_stb_o : cycle and strobe
//   wb_we_o           : write enable (always 0 on this bus)
//   wb_adr_o/wb_sel_o : byte address and byte selects
//   wb_dat_i          : MDW-bit read line
//   wb_ack_i/wb_err_i : termination
interface gfx256_wbm_read_arbiter_if
  import gfx256_pkg::*;
#(
  parameter int MDW = 256
) ();
  logic             wb_cyc_o;
  logic             wb_stb_o;
  logic             wb_we_o;
  logic [WB_AW-1:0] wb_adr_o;
  logic [WB_SW-1:0] wb_sel_o;
  logic [MDW-1:0]   wb_dat_i;
  logic             wb_ack_i;
  logic             wb_err_i;

  modport master (
    output wb_cyc_o, wb_stb_o, wb_we_o, wb_adr_o, wb_sel_o,
    input  wb_dat_i, wb_ack_i, wb_err_i
  );

  modport slave (
    input  wb_cyc_o, wb_stb_o, wb_we_o, wb_adr_o, wb_sel_o,
    output wb_dat_i, wb_ack_i, wb_err_i
  );
endinterface

// File: rtl/gfx256_rr_pick.sv
// gfx256_rr_pick: combinational round-robin picker.
//   i_req    : request vector
//   i_ptr    : index with highest priority this round
//   o_onehot : one-hot winner
//   o_idx    : winner index
//   o_valid  : at least one request present
module gfx256_rr_pick
  import gfx256_pkg::*;
#(
  parameter  int NREQ = 3,
  localparam int IW   = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] i_req,
  input  logic [IW-1:0]   i_ptr,
  output logic [NREQ-1:0] o_onehot,
  output logic [IW-1:0]   o_idx,
  output logic            o_valid
);

  int w_k;

  // Walk the requesters starting at i_ptr; the first one set wins.
  always_comb begin
    o_onehot = '0;
    o_idx    = '0;
    o_valid  = 1'b0;
    w_k      = int'(i_ptr);
    for (int i = 0; i < NREQ; i++) begin
      if (!o_valid && i_req[w_k]) begin
        o_valid       = 1'b1;
        o_idx         = IW'(w_k);
        o_onehot[w_k] = 1'b1;
      end
      w_k = rr_next(w_k, NREQ);
    end
  end

endmodule

// File: rtl/gfx256_wbm_read_arbiter.sv
// gfx256_wbm_read_arbiter: shares one single-beat Wishbone read master among
// NREQ requesters (0 blender target, 1 texture, 2 depth) with round-robin
// grants and a bus watchdog.
//   clk_i, rst_ni      : clock, asynchronous active-low reset
//   req_i              : level request per requester, held until its ack_o
//   addr_i, sel_i      : per-requester address / byte selects, 32 bits each
//   ack_o, err_o       : one-cycle completion (and error) pulse to the grantee
//   busy_o             : set for every non-granted requester while busy
//   data_o             : read line, valid in the ack_o cycle
//   wb                 : Wishbone read master port
module gfx256_wbm_read_arbiter
  import gfx256_pkg::*;
#(
  parameter  int NREQ    = 3,
  parameter  int MDW     = 256,
  parameter  int TIMEOUT = 1023,
  localparam int IW      = $clog2(NREQ)
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic [NREQ-1:0]      req_i,
  input  logic [NREQ*32-1:0]   addr_i,
  input  logic [NREQ*32-1:0]   sel_i,
  output logic [NREQ-1:0]      ack_o,
  output logic [NREQ-1:0]      err_o,
  output logic [NREQ-1:0]      busy_o,
  output logic [MDW-1:0]       data_o,
  gfx256_wbm_read_arbiter_if.master wb
);

  arb_state_e        r_state, w_state_nxt;
  logic [IW-1:0]     r_ptr, w_ptr_nxt;
  logic [IW-1:0]     r_grant, w_grant_nxt;
  logic [WDOG_W-1:0] r_cnt, w_cnt_nxt;
  logic              r_cyc, w_cyc_nxt;
  logic [WB_AW-1:0]  r_adr, w_adr_nxt;
  logic [WB_SW-1:0]  r_sel, w_sel_nxt;
  logic [NREQ-1:0]   r_ack, w_ack_nxt;
  logic [NREQ-1:0]   r_err, w_err_nxt;
  logic [NREQ-1:0]   r_busy, w_busy_nxt;
  logic [MDW-1:0]    r_data, w_data_nxt;

  logic [NREQ-1:0]   w_pick_oh;
  logic [IW-1:0]     w_pick_idx;
  logic              w_pick_vld;
  logic              w_bus_done;
  logic              w_timeout;

  gfx256_rr_pick #(.NREQ(NREQ)) u_pick (
    .i_req    (req_i),
    .i_ptr    (r_ptr),
    .o_onehot (w_pick_oh),
    .o_idx    (w_pick_idx),
    .o_valid  (w_pick_vld)
  );

  assign w_bus_done = wb.wb_ack_i | wb.wb_err_i;
  // The watchdog fires on the edge that would bring the count to TIMEOUT,
  // so a read lasts at most TIMEOUT cycles in READ.
  assign w_timeout  = (r_cnt + 1'b1) == WDOG_W'(TIMEOUT);

  always_comb begin
    w_state_nxt = r_state;
    w_ptr_nxt   = r_ptr;
    w_grant_nxt = r_grant;
    w_cnt_nxt   = r_cnt;
    w_cyc_nxt   = r_cyc;
    w_adr_nxt   = r_adr;
    w_sel_nxt   = r_sel;
    w_ack_nxt   = '0;
    w_err_nxt   = '0;
    w_data_nxt  = r_data;
    w_busy_nxt  = '0;
    unique case (r_state)
      IDLE: begin
        if (w_pick_vld) begin
          w_state_nxt = READ;
          w_grant_nxt = w_pick_idx;
          w_cnt_nxt   = '0;
          w_cyc_nxt   = 1'b1;
          for (int k = 0; k < NREQ; k++) begin
            if (w_pick_oh[k]) begin
              w_adr_nxt = addr_i[32*k +: 32];
              w_sel_nxt = sel_i[32*k +: 32];
            end
          end
        end
      end
      READ: begin
        if (w_bus_done) begin
          w_state_nxt        = DONE;
          w_cyc_nxt          = 1'b0;
          w_data_nxt         = wb.wb_dat_i;
          w_ack_nxt[r_grant] = 1'b1;
          w_err_nxt[r_grant] = wb.wb_err_i;
          w_ptr_nxt          = IW'(rr_next(int'(r_grant), NREQ));
        end else if (w_timeout) begin
          // Abort: data_o keeps its previous line.
          w_state_nxt        = DONE;
          w_cyc_nxt          = 1'b0;
          w_ack_nxt[r_grant] = 1'b1;
          w_err_nxt[r_grant] = 1'b1;
          w_ptr_nxt          = IW'(rr_next(int'(r_grant), NREQ));
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      DONE: begin
        // Hold-off: the just-acked requester still shows req_i this cycle.
        w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
    for (int k = 0; k < NREQ; k++) begin
      w_busy_nxt[k] = (w_state_nxt != IDLE) && (w_grant_nxt != IW'(k));
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state <= IDLE;
      r_ptr   <= '0;
      r_grant <= '0;
      r_cnt   <= '0;
      r_cyc   <= 1'b0;
      r_adr   <= '0;
      r_sel   <= '0;
      r_ack   <= '0;
      r_err   <= '0;
      r_busy  <= '0;
      r_data  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_ptr   <= w_ptr_nxt;
      r_grant <= w_grant_nxt;
      r_cnt   <= w_cnt_nxt;
      r_cyc   <= w_cyc_nxt;
      r_adr   <= w_adr_nxt;
      r_sel   <= w_sel_nxt;
      r_ack   <= w_ack_nxt;
      r_err   <= w_err_nxt;
      r_busy  <= w_busy_nxt;
      r_data  <= w_data_nxt;
    end
  end

  assign wb.wb_cyc_o = r_cyc;
  assign wb.wb_stb_o = r_cyc;
  assign wb.wb_we_o  = 1'b0;
  assign wb.wb_adr_o = r_adr;
  assign wb.wb_sel_o = r_sel;
  assign ack_o       = r_ack;
  assign err_o       = r_err;
  assign busy_o      = r_busy;
  assign data_o      = r_data;

endmodule

// File: tb/tb_gfx256_wbm_read_arbiter.sv
// tb_gfx256_wbm_read_arbiter: directed plus randomized bench for the read
// arbiter with a transaction-level reference model (grant pointer, last line).
module tb_gfx256_wbm_read_arbiter;
  import gfx256_pkg::*;

  localparam int NREQ = 3;
  localparam int MDW  = 256;
  localparam int TO   = 8;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [NREQ-1:0]   req;
  logic [NREQ*32-1:0] addr, sel;
  logic [NREQ-1:0]   ack, err, busy;
  logic [MDW-1:0]    data;

  always #5 clk = ~clk;

  gfx256_wbm_read_arbiter_if #(.MDW(MDW)) wb_if ();

  gfx256_wbm_read_arbiter #(.NREQ(NREQ), .MDW(MDW), .TIMEOUT(TO)) dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .req_i  (req),
    .addr_i (addr),
    .sel_i  (sel),
    .ack_o  (ack),
    .err_o  (err),
    .busy_o (busy),
    .data_o (data),
    .wb     (wb_if)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int m_ptr;
  logic [MDW-1:0] m_data;

  function automatic int model_pick(input logic [NREQ-1:0] r, input int p);
    for (int i = 0; i < NREQ; i++) begin
      if (r[(p + i) % NREQ]) return (p + i) % NREQ;
    end
    return -1;
  endfunction

  function automatic logic [MDW-1:0] rand_line();
    logic [MDW-1:0] v;
    for (int i = 0; i < MDW / 32; i++) v[32*i +: 32] = $urandom;
    return v;
  endfunction

  task automatic chk(input string tag, input logic [MDW-1:0] obs, input logic [MDW-1:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // kind: 0 ack, 1 err, 2 ack+err, 3 no response (watchdog)
  task automatic run_read(input int waits, input int kind, input logic [MDW-1:0] rdata,
                          input bit drop_mid, output int w);
    logic [31:0]     e_adr, e_sel;
    logic [NREQ-1:0] e_busy, e_one;
    int              resp;
    w = model_pick(req, m_ptr);
    if (w < 0) begin
      n_tests++;
      n_fail++;
      $error("FAIL pick no_request observed=%0h expected=nonzero", req);
      return;
    end
    e_adr  = addr[32*w +: 32];
    e_sel  = sel[32*w +: 32];
    e_one  = NREQ'(1) << w;
    e_busy = ~e_one;
    @(posedge clk); #1;
    // Requester inputs change after grant; the bus must keep the latched values.
    addr = {$urandom, $urandom, $urandom};
    sel  = {$urandom, $urandom, $urandom};
    if (drop_mid) req[w] = 1'b0;
    resp = (kind == 3) ? TO : waits + 1;
    for (int c = 1; c <= resp; c++) begin
      if (c == resp && kind != 3) begin
        wb_if.wb_ack_i = (kind == 0 || kind == 2);
        wb_if.wb_err_i = (kind == 1 || kind == 2);
        wb_if.wb_dat_i = rdata;
      end
      @(negedge clk);
      chk("read_cyc",  wb_if.wb_cyc_o, 1);
      chk("read_stb",  wb_if.wb_stb_o, 1);
      chk("read_we",   wb_if.wb_we_o, 0);
      chk("read_adr",  wb_if.wb_adr_o, e_adr);
      chk("read_sel",  wb_if.wb_sel_o, e_sel);
      chk("read_busy", busy, e_busy);
      chk("read_ack",  ack, 0);
      @(posedge clk); #1;
      wb_if.wb_ack_i = 1'b0;
      wb_if.wb_err_i = 1'b0;
      wb_if.wb_dat_i = rand_line();
    end
    if (kind != 3) m_data = rdata;
    m_ptr = (w + 1) % NREQ;
    @(negedge clk);
    chk("done_cyc",  wb_if.wb_cyc_o, 0);
    chk("done_stb",  wb_if.wb_stb_o, 0);
    chk("done_ack",  ack, e_one);
    chk("done_err",  err, (kind != 0) ? e_one : '0);
    chk("done_data", data, m_data);
    chk("done_busy", busy, e_busy);
    @(posedge clk); #1;
    req[w] = 1'b0;
    @(negedge clk);
    chk("idle_ack",  ack, 0);
    chk("idle_err",  err, 0);
    chk("idle_cyc",  wb_if.wb_cyc_o, 0);
    chk("idle_busy", busy, 0);
  endtask

  initial begin
    int w, kind, waits;
    bit drop;
    rst_n = 1'b0;
    req   = '0;
    addr  = '0;
    sel   = '0;
    wb_if.wb_dat_i = '0;
    wb_if.wb_ack_i = 1'b0;
    wb_if.wb_err_i = 1'b0;
    m_ptr  = 0;
    m_data = '0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_cyc",  wb_if.wb_cyc_o, 0);
    chk("rst_stb",  wb_if.wb_stb_o, 0);
    chk("rst_we",   wb_if.wb_we_o, 0);
    chk("rst_adr",  wb_if.wb_adr_o, 0);
    chk("rst_sel",  wb_if.wb_sel_o, 0);
    chk("rst_ack",  ack, 0);
    chk("rst_err",  err, 0);
    chk("rst_busy", busy, 0);
    chk("rst_data", data, 0);
    rst_n = 1'b1;

    // Round-robin with all three requesting; each drops only after its ack.
    addr = {$urandom, $urandom, $urandom};
    sel  = {$urandom, $urandom, $urandom};
    req  = 3'b111;
    run_read(0, 0, rand_line(), 1'b0, w); chk("rr_grant0", w, 0);
    run_read(1, 0, rand_line(), 1'b0, w); chk("rr_grant1", w, 1);
    run_read(0, 0, rand_line(), 1'b0, w); chk("rr_grant2", w, 2);
    req[0] = 1'b1;
    run_read(0, 0, rand_line(), 1'b0, w); chk("rr_grant3", w, 0);

    // Single request from the blender target, two wait states.
    req = 3'b001;
    addr[31:0] = 32'h0000_1000;
    sel[31:0]  = 32'hFFFF_FFFF;
    run_read(2, 0, {32{8'hA5}}, 1'b0, w);
    chk("single_grant", w, REQ_BLEND);
    chk("single_data",  data, {32{8'hA5}});

    // Bus error on the first READ cycle for the texture unit, then ptr = 2.
    req = 3'b010;
    run_read(0, 1, rand_line(), 1'b0, w);
    chk("err_grant", w, REQ_TEX);
    req = 3'b111;
    run_read(0, 0, rand_line(), 1'b0, w);
    chk("err_ptr_next", w, REQ_DEPTH);
    req = '0;

    // Watchdog: no response at all; data_o must keep the previous line.
    req = 3'b100;
    run_read(0, 3, rand_line(), 1'b0, w);
    chk("to_grant", w, REQ_DEPTH);

    // Ack and err together: error with data captured.
    req = 3'b001;
    run_read(1, 2, rand_line(), 1'b0, w);

    // Randomized traffic.
    for (int t = 0; t < 40; t++) begin
      req = req | NREQ'($urandom_range(0, 7));
      if (req == '0) req[$urandom_range(0, NREQ - 1)] = 1'b1;
      kind  = ($urandom_range(0, 9) == 0) ? 3 : int'($urandom_range(0, 2));
      waits = int'($urandom_range(0, 3));
      drop  = ($urandom_range(0, 3) == 0);
      run_read(waits, kind, rand_line(), drop, w);
    end

    // Asynchronous reset in the middle of a read.
    @(posedge clk); #1;
    req = 3'b010;
    @(posedge clk); #1;
    @(posedge clk); #1;
    @(negedge clk);
    chk("arst_before", wb_if.wb_cyc_o, 1);
    #2;
    rst_n = 1'b0;
    req   = '0;
    wb_if.wb_ack_i = 1'b1;
    #1;
    chk("arst_cyc", wb_if.wb_cyc_o, 0);
    chk("arst_stb", wb_if.wb_stb_o, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    wb_if.wb_ack_i = 1'b0;
    m_ptr  = 0;
    m_data = '0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("arst_ack",  ack, 0);
      chk("arst_cyc2", wb_if.wb_cyc_o, 0);
      chk("arst_busy", busy, 0);
    end
    chk("arst_data", data, 0);
    req = 3'b111;
    run_read(0, 0, rand_line(), 1'b0, w);
    chk("arst_ptr", w, 0);
    req = '0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
